avalon_axi_lite_bridge: RTL and testbench

AVALON_AXI_LITE_BRIDGE -- requirements
Module: avalon_axi_lite_bridge

---
 rtl/avalon_axi_lite_bridge.sv | 130 +++++++++++++
 tb/tb_avalon_axi_lite_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_axi_lite_bridge.sv
// avalon_axi_lite_bridge: Avalon-MM slave to AXI4-Lite master bridge, one transaction at a time with timeout
module avalon_axi_lite_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESET,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [ADDR_WIDTH-1:0]   avs_address,
    input  logic [DATA_WIDTH-1:0]   avs_writedata,
    input  logic [DATA_WIDTH/8-1:0] avs_byteenable,
    output logic                    avs_waitrequest,
    output logic [DATA_WIDTH-1:0]   avs_readdata,
    output logic                    avs_readdatavalid,
    output logic [1:0]              avs_response,
    output logic                    proto_err,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        DONE         = 3'd5
    } state_t;

    state_t          state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]   strb_q;
    logic            aw_pend, w_pend, is_rd, busy, tmo;
    logic [CW-1:0]   cnt;

    assign busy = state inside {WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA};
    // the edge ending the last allowed wait cycle aborts the transaction
    assign tmo = TIMEOUT_CYCLES != 0 && busy && cnt == CW'(TIMEOUT_CYCLES - 1);

    // state register
    always_ff @(posedge M_AXI_ACLK) begin
        state <= M_AXI_ARESET ? IDLE : state_nx;
    end

    // next-state logic; a simultaneous read and write is treated as a write
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:         state_nx = avs_write ? WR_ADDR_DATA : avs_read ? RD_ADDR : IDLE;
            WR_ADDR_DATA: state_nx = tmo ? DONE :
                                     (!aw_pend || M_AXI_AWREADY) && (!w_pend || M_AXI_WREADY) ? WR_RESP : WR_ADDR_DATA;
            WR_RESP:      state_nx = tmo || M_AXI_BVALID ? DONE : WR_RESP;
            RD_ADDR:      state_nx = tmo ? DONE : M_AXI_ARREADY ? RD_DATA : RD_ADDR;
            RD_DATA:      state_nx = tmo || M_AXI_RVALID ? DONE : RD_DATA;
            default:      state_nx = IDLE;
        endcase
    end

    // command latch, per-channel pending flags, timeout counter and completion data
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            aw_pend      <= 1'b0;
            w_pend       <= 1'b0;
            is_rd        <= 1'b0;
            cnt          <= '0;
            avs_readdata <= '0;
            avs_response <= 2'b00;
            proto_err    <= 1'b0;
        end else begin
            cnt     <= state == IDLE ? '0 : busy ? cnt + CW'(1) : cnt;
            aw_pend <= tmo ? 1'b0 : state == IDLE ? avs_write : aw_pend && !M_AXI_AWREADY;
            w_pend  <= tmo ? 1'b0 : state == IDLE ? avs_write : w_pend && !M_AXI_WREADY;
            if (state == IDLE && (avs_read || avs_write)) begin
                addr_q  <= avs_address;
                wdata_q <= avs_writedata;
                strb_q  <= avs_byteenable;
                is_rd   <= !avs_write;
            end
            if (state == IDLE && avs_read && avs_write) proto_err <= 1'b1;
            if (tmo) begin
                avs_response <= 2'b11;
                avs_readdata <= '0;
            end else if (state == WR_RESP && M_AXI_BVALID) begin
                avs_response <= M_AXI_BRESP;
            end else if (state == RD_DATA && M_AXI_RVALID) begin
                avs_readdata <= M_AXI_RDATA;
                avs_response <= M_AXI_RRESP;
            end
        end
    end

    // outputs decoded from state and registered flags only
    always_comb begin
        avs_waitrequest   = state != DONE;
        avs_readdatavalid = state == DONE && is_rd;
        M_AXI_AWADDR      = addr_q;
        M_AXI_AWPROT      = 3'b000;
        M_AXI_AWVALID     = aw_pend;
        M_AXI_WDATA       = wdata_q;
        M_AXI_WSTRB       = strb_q;
        M_AXI_WVALID      = w_pend;
        M_AXI_BREADY      = state == WR_RESP;
        M_AXI_ARADDR      = addr_q;
        M_AXI_ARPROT      = 3'b000;
        M_AXI_ARVALID     = state == RD_ADDR;
        M_AXI_RREADY      = state == RD_DATA;
    end
endmodule

// File: tb/tb_avalon_axi_lite_bridge.sv
// tb_avalon_axi_lite_bridge: directed checks of the bridge against a scripted AXI4-Lite slave
module tb_avalon_axi_lite_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_address = '0, avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic        avs_waitrequest, avs_readdatavalid, proto_err;
    logic [31:0] avs_readdata;
    logic [1:0]  avs_response;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic b_force = 1'b0, r_force = 1'b0;
    logic [31:0] rdata_v = '0;
    logic [1:0]  rresp_v = 2'b00, bresp_v = 2'b00;

    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, aw_hi = 0, w_hi = 0, ar_hi = 0, rdv_n = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;

    int checks = 0, errors = 0;
    int lat;
    int s0, s1, s2, s3;

    always #5 clk = ~clk;

    avalon_axi_lite_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .avs_read(avs_read), .avs_write(avs_write), .avs_address(avs_address),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .avs_response(avs_response), .proto_err(proto_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // scripted slave: each ready/valid answers after its configured number of waiting cycles
    always @(negedge clk) begin
        #1;
        aw_wait = awvalid ? aw_wait + 1 : 0;
        w_wait  = wvalid  ? w_wait + 1  : 0;
        b_wait  = bready  ? b_wait + 1  : 0;
        ar_wait = arvalid ? ar_wait + 1 : 0;
        r_wait  = rready  ? r_wait + 1  : 0;
        awready = awvalid && aw_wait > aw_delay;
        wready  = wvalid && w_wait > w_delay;
        arready = arvalid && ar_wait > ar_delay;
        bvalid  = b_force || (bready && b_wait > b_delay);
        rvalid  = r_force || (rready && r_wait > r_delay);
        bresp   = bresp_v;
        rresp   = rresp_v;
        rdata   = rdata_v;
    end

    // bus monitor: cumulative handshake and valid-high counts, captured payloads
    always @(posedge clk) begin
        if (awvalid) aw_hi++;
        if (wvalid) w_hi++;
        if (arvalid) ar_hi++;
        if (avs_readdatavalid) rdv_n++;
        if (awvalid && awready) begin aw_hs++; cap_awaddr = awaddr; end
        if (wvalid && wready) begin w_hs++; cap_wdata = wdata; cap_wstrb = wstrb; end
        if (bvalid && bready) b_hs++;
        if (arvalid && arready) begin ar_hs++; cap_araddr = araddr; end
        if (rvalid && rready) r_hs++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one-cycle command pulse, then wait (bounded) for the completion cycle
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int n);
        @(negedge clk);
        avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d; avs_byteenable = be;
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        n = 1;
        while (avs_waitrequest && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_wait", avs_waitrequest, 1);
        chk("rst_rdv", avs_readdatavalid, 0);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        chk("rst_resp", avs_response, 0);
        chk("rst_rdata", avs_readdata, 0);
        chk("rst_perr", proto_err, 0);
        rst = 1'b0;

        s0 = aw_hs; s1 = w_hs; s2 = b_hs;
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, lat);
        chk("wr_lat", lat, 3);
        chk("wr_resp", avs_response, 0);
        chk("wr_rdv", avs_readdatavalid, 0);
        chk("wr_aw_hs", aw_hs - s0, 1);
        chk("wr_w_hs", w_hs - s1, 1);
        chk("wr_b_hs", b_hs - s2, 1);
        chk("wr_awaddr", cap_awaddr, 32'h10);
        chk("wr_wdata", cap_wdata, 32'hDEADBEEF);
        chk("wr_wstrb", cap_wstrb, 4'hF);
        chk("wr_prot", {awprot, arprot}, 0);
        @(negedge clk);
        chk("wr_done_1cyc", avs_waitrequest, 1);

        aw_delay = 5;
        s0 = aw_hi; s1 = w_hi; s2 = b_hs;
        issue(0, 1, 32'h44, 32'h0BADF00D, 4'h3, lat);
        chk("awdly_lat", lat, 8);
        chk("awdly_aw_hi", aw_hi - s0, 6);
        chk("awdly_w_hi", w_hi - s1, 1);
        chk("awdly_b_hs", b_hs - s2, 1);
        chk("awdly_wstrb", cap_wstrb, 4'h3);
        aw_delay = 0; w_delay = 2;
        s0 = aw_hi; s1 = w_hi;
        issue(0, 1, 32'h48, 32'h5, 4'h1, lat);
        chk("wdly_lat", lat, 5);
        chk("wdly_aw_hi", aw_hi - s0, 1);
        chk("wdly_w_hi", w_hi - s1, 3);
        w_delay = 0;

        r_delay = 3; rdata_v = 32'h12345678; rresp_v = 2'b10;
        s0 = rdv_n; s1 = ar_hs;
        issue(1, 0, 32'h20, 32'h0, 4'h0, lat);
        chk("rd_lat", lat, 6);
        chk("rd_data", avs_readdata, 32'h12345678);
        chk("rd_resp", avs_response, 2'b10);
        chk("rd_rdv", avs_readdatavalid, 1);
        chk("rd_araddr", cap_araddr, 32'h20);
        chk("rd_ar_hs", ar_hs - s1, 1);
        @(negedge clk);
        chk("rd_rdv_once", rdv_n - s0, 1);
        r_delay = 0; rdata_v = 32'hCAFE0001; rresp_v = 2'b00;
        issue(1, 0, 32'h24, 32'h0, 4'h0, lat);
        chk("rd_min_lat", lat, 3);
        chk("rd_min_data", avs_readdata, 32'hCAFE0001);

        ar_delay = 1000;
        s1 = ar_hs;
        issue(1, 0, 32'h30, 32'h0, 4'h0, lat);
        chk("tmo_lat", lat, 17);
        chk("tmo_arvalid", arvalid, 0);
        chk("tmo_resp", avs_response, 2'b11);
        chk("tmo_rdata", avs_readdata, 0);
        chk("tmo_ar_hs", ar_hs - s1, 0);
        ar_delay = 0;

        @(negedge clk);
        b_force = 1'b1; r_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stray_ready", {bready, rready}, 0);
        b_force = 1'b0; r_force = 1'b0;
        @(negedge clk);

        s0 = aw_hs; s1 = ar_hi;
        issue(1, 1, 32'h50, 32'h11112222, 4'hF, lat);
        chk("both_perr", proto_err, 1);
        chk("both_aw_hs", aw_hs - s0, 1);
        chk("both_no_ar", ar_hi - s1, 0);
        chk("both_rdv", avs_readdatavalid, 0);
        bresp_v = 2'b01;
        issue(0, 1, 32'h54, 32'h3, 4'hF, lat);
        chk("perr_sticky", proto_err, 1);
        chk("bresp_cap", avs_response, 2'b01);
        bresp_v = 2'b00;

        b_delay = 1000;
        @(negedge clk);
        avs_write = 1'b1; avs_address = 32'h60; avs_writedata = 32'h7; avs_byteenable = 4'hF;
        @(negedge clk);
        avs_write = 1'b0;
        lat = 0;
        while (!bready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("mid_bready", bready, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_bready", bready, 0);
        chk("mid_rst_wait", avs_waitrequest, 1);
        chk("mid_rst_perr", proto_err, 0);
        chk("mid_rst_resp", avs_response, 0);
        rst = 1'b0; b_delay = 0;
        rdata_v = 32'hA5A50001; rresp_v = 2'b01;
        issue(1, 0, 32'h70, 32'h0, 4'h0, lat);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_data", avs_readdata, 32'hA5A50001);
        chk("post_rst_resp", avs_response, 2'b01);
        chk("post_rst_rdv", avs_readdatavalid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
